// File: rtl/wb_rr_arbiter_if.sv
// Wishbone bundle for wb_rr_arbiter: master-side request/response plus
// the single slave-side port. slave = arbiter view, master = environment view.
interface wb_rr_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32
);
  localparam int SW = DW / 8;

  logic [NUM_MASTERS*AW-1:0] wbm_adr_i;
  logic [NUM_MASTERS*DW-1:0] wbm_dat_i;
  logic [NUM_MASTERS*SW-1:0] wbm_sel_i;
  logic [NUM_MASTERS-1:0]    wbm_we_i;
  logic [NUM_MASTERS-1:0]    wbm_cyc_i;
  logic [NUM_MASTERS-1:0]    wbm_stb_i;
  logic [NUM_MASTERS*3-1:0]  wbm_cti_i;
  logic [NUM_MASTERS*2-1:0]  wbm_bte_i;
  logic [DW-1:0]             wbm_dat_o;
  logic [NUM_MASTERS-1:0]    wbm_ack_o;
  logic [NUM_MASTERS-1:0]    wbm_err_o;
  logic [NUM_MASTERS-1:0]    wbm_rty_o;

  logic [AW-1:0] wbs_adr_o;
  logic [DW-1:0] wbs_dat_o;
  logic [SW-1:0] wbs_sel_o;
  logic          wbs_we_o;
  logic          wbs_cyc_o;
  logic          wbs_stb_o;
  logic [2:0]    wbs_cti_o;
  logic [1:0]    wbs_bte_o;
  logic [DW-1:0] wbs_dat_i;
  logic          wbs_ack_i;
  logic          wbs_err_i;
  logic          wbs_rty_i;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i,
    input  wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o,
    output wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
    input  wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i,
    output wbm_cyc_i, wbm_stb_i, wbm_cti_i, wbm_bte_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o,
    input  wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o,
    output wbs_dat_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 arbiter, one grant per cyc window.
// Optional watchdog: define WB_RR_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_rr_arbiter_if.slave         bus,
  output logic [NUM_MASTERS-1:0] gnt_o
);
  localparam int LW = $clog2(NUM_MASTERS);
  localparam int SW = DW / 8;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OWNED = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [LW-1:0]          last_q, last_d;
  logic [LW-1:0]          pick;
  logic                   any_req;
  logic                   own_cyc;
  logic                   req_stb;
  logic                   timeout;

  assign own_cyc = |(bus.wbm_cyc_i & gnt_q);
  assign req_stb = |(bus.wbm_stb_i & gnt_q);

  // first requester after the last granted one, wrapping
  always_comb begin
    logic [LW:0] idx;
    pick    = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = {1'b0, last_q} + (LW+1)'(i);
      if (idx >= (LW+1)'(NUM_MASTERS))
        idx = idx - (LW+1)'(NUM_MASTERS);
      if (!any_req && bus.wbm_cyc_i[idx[LW-1:0]]) begin
        any_req = 1'b1;
        pick    = idx[LW-1:0];
      end
    end
  end

  // grant FSM: hold the owner for its whole cyc window
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = NUM_MASTERS'(1) << pick;
          last_d  = pick;
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (!own_cyc) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // state registers with synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LW'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

`ifdef WB_RR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          resp;
  logic          stalled;

  assign resp    = bus.wbs_ack_i | bus.wbs_err_i | bus.wbs_rty_i;
  assign stalled = own_cyc & req_stb & ~resp;
  assign timeout = stalled && (cnt_q == CW'(TIMEOUT - 1));

  // count stalled strobe cycles of the current owner
  always_comb begin
    cnt_d = cnt_q;
    if (resp || (gnt_d != gnt_q) || timeout)
      cnt_d = '0;
    else if (stalled)
      cnt_d = cnt_q + CW'(1);
  end

  // watchdog counter register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  // request mux: OR of masked fields, gnt is one-hot or zero
  always_comb begin
    bus.wbs_adr_o = '0;
    bus.wbs_dat_o = '0;
    bus.wbs_sel_o = '0;
    bus.wbs_we_o  = 1'b0;
    bus.wbs_cti_o = '0;
    bus.wbs_bte_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_q[i]) begin
        bus.wbs_adr_o = bus.wbs_adr_o | bus.wbm_adr_i[i*AW +: AW];
        bus.wbs_dat_o = bus.wbs_dat_o | bus.wbm_dat_i[i*DW +: DW];
        bus.wbs_sel_o = bus.wbs_sel_o | bus.wbm_sel_i[i*SW +: SW];
        bus.wbs_we_o  = bus.wbs_we_o  | bus.wbm_we_i[i];
        bus.wbs_cti_o = bus.wbs_cti_o | bus.wbm_cti_i[i*3 +: 3];
        bus.wbs_bte_o = bus.wbs_bte_o | bus.wbm_bte_i[i*2 +: 2];
      end
    end
  end

  assign bus.wbs_cyc_o = own_cyc;
  assign bus.wbs_stb_o = req_stb & ~timeout;

  assign bus.wbm_dat_o = bus.wbs_dat_i;
  assign bus.wbm_ack_o = gnt_q & {NUM_MASTERS{bus.wbs_ack_i}};
  assign bus.wbm_err_o = gnt_q & {NUM_MASTERS{bus.wbs_err_i | timeout}};
  assign bus.wbm_rty_o = gnt_q & {NUM_MASTERS{bus.wbs_rty_i}};

  assign gnt_o = gnt_q;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (3 masters, 32-bit bus).
// Watchdog scenario compiled in when WB_RR_ARB_TIMEOUT_EN is defined.
module tb_wb_rr_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] gnt_o;
  int           n_cmp = 0;
  int           n_fail = 0;

  wb_rr_arbiter_if #(.NUM_MASTERS(N), .AW(AW), .DW(DW)) bus ();

  wb_rr_arbiter #(
    .NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(16)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus),
    .gnt_o    (gnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_bus();
    bus.wbm_adr_i = {32'hb300_0010, 32'h2000_0000, 32'h1000_0000};
    bus.wbm_dat_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    bus.wbm_sel_i = {4'hf, 4'h3, 4'hc};
    bus.wbm_we_i  = '0;
    bus.wbm_cyc_i = '0;
    bus.wbm_stb_i = '0;
    bus.wbm_cti_i = '0;
    bus.wbm_bte_i = '0;
    bus.wbs_dat_i = 32'hdead_beef;
    bus.wbs_ack_i = 1'b0;
    bus.wbs_err_i = 1'b0;
    bus.wbs_rty_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.wbs_ack_i = 1'b1;
    #1;
    n_cmp++;
    if (gnt_o !== 3'b000) begin
      n_fail++; $display("FAIL rst_gnt: got %b want 000", gnt_o);
    end
    n_cmp++;
    if (bus.wbs_cyc_o !== 1'b0 || bus.wbs_stb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_cyc: got %b%b want 00", bus.wbs_cyc_o, bus.wbs_stb_o);
    end
    n_cmp++;
    if (bus.wbm_ack_o !== 3'b000) begin
      n_fail++; $display("FAIL stale_ack: got %b want 000", bus.wbm_ack_o);
    end
    n_cmp++;
    if (bus.wbm_dat_o !== 32'hdead_beef) begin
      n_fail++; $display("FAIL dat_bcast: got %h want deadbeef", bus.wbm_dat_o);
    end
    bus.wbs_ack_i = 1'b0;
  endtask

  task automatic test_simultaneous();
    bus.wbm_cyc_i = 3'b101;
    bus.wbm_stb_i = 3'b101;
    bus.wbm_we_i  = 3'b100;
    tick();
    n_cmp++;
    if (gnt_o !== 3'b001) begin
      n_fail++; $display("FAIL sim_gnt0: got %b want 001", gnt_o);
    end
    n_cmp++;
    if (bus.wbs_adr_o !== 32'h1000_0000 || bus.wbs_we_o !== 1'b0 ||
        bus.wbs_cyc_o !== 1'b1 || bus.wbs_stb_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_req0: got adr %h we %b cyc %b stb %b want 10000000 0 1 1",
               bus.wbs_adr_o, bus.wbs_we_o, bus.wbs_cyc_o, bus.wbs_stb_o);
    end
    n_cmp++;
    if (bus.wbs_sel_o !== 4'hc || bus.wbs_dat_o !== 32'h1111_1111) begin
      n_fail++;
      $display("FAIL sim_dat0: got sel %h dat %h want c 11111111",
               bus.wbs_sel_o, bus.wbs_dat_o);
    end
    bus.wbs_ack_i = 1'b1;
    #1;
    n_cmp++;
    if (bus.wbm_ack_o !== 3'b001) begin
      n_fail++; $display("FAIL sim_ack0: got %b want 001", bus.wbm_ack_o);
    end
    tick();
    bus.wbs_ack_i    = 1'b0;
    bus.wbm_cyc_i[0] = 1'b0;
    bus.wbm_stb_i[0] = 1'b0;
    tick();
    n_cmp++;
    if (gnt_o !== 3'b000 || bus.wbs_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_idle: got gnt %b cyc %b want 000 0", gnt_o, bus.wbs_cyc_o);
    end
    tick();
    n_cmp++;
    if (gnt_o !== 3'b100) begin
      n_fail++; $display("FAIL sim_gnt2: got %b want 100", gnt_o);
    end
    n_cmp++;
    if (bus.wbs_adr_o !== 32'hb300_0010 || bus.wbs_we_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_req2: got adr %h we %b want b3000010 1",
               bus.wbs_adr_o, bus.wbs_we_o);
    end
    bus.wbm_cyc_i = '0;
    bus.wbm_stb_i = '0;
    bus.wbm_we_i  = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    bus.wbm_cyc_i = 3'b111;
    bus.wbm_stb_i = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp_g = 3'b001 << (k % 3);
      tick();
      n_cmp++;
      if (gnt_o !== exp_g) begin
        n_fail++; $display("FAIL rr_gnt%0d: got %b want %b", k, gnt_o, exp_g);
      end
      bus.wbs_ack_i = 1'b1;
      #1;
      n_cmp++;
      if (bus.wbm_ack_o !== exp_g) begin
        n_fail++;
        $display("FAIL rr_ack%0d: got %b want %b", k, bus.wbm_ack_o, exp_g);
      end
      tick();
      bus.wbs_ack_i         = 1'b0;
      bus.wbm_cyc_i[k % 3]  = 1'b0;
      bus.wbm_stb_i[k % 3]  = 1'b0;
      tick();
      n_cmp++;
      if (gnt_o !== 3'b000) begin
        n_fail++; $display("FAIL rr_idle%0d: got %b want 000", k, gnt_o);
      end
      bus.wbm_cyc_i[k % 3] = 1'b1;
      bus.wbm_stb_i[k % 3] = 1'b1;
    end
    bus.wbm_cyc_i = '0;
    bus.wbm_stb_i = '0;
    tick();
  endtask

  task automatic test_burst();
    logic [2:0]  exp_cti;
    logic [31:0] exp_adr;
    bus.wbm_cyc_i[1] = 1'b1;
    bus.wbm_stb_i[1] = 1'b1;
    bus.wbm_cti_i[5:3] = 3'b010;
    tick();
    n_cmp++;
    if (gnt_o !== 3'b010) begin
      n_fail++; $display("FAIL burst_gnt: got %b want 010", gnt_o);
    end
    bus.wbm_cyc_i[0] = 1'b1;
    bus.wbm_stb_i[0] = 1'b1;
    for (int b = 0; b < 4; b++) begin
      exp_adr = 32'h2000_0000 + 32'(4 * b);
      exp_cti = (b == 3) ? 3'b111 : 3'b010;
      bus.wbm_adr_i[63:32] = exp_adr;
      bus.wbm_cti_i[5:3]   = exp_cti;
      bus.wbs_ack_i        = 1'b1;
      #1;
      n_cmp++;
      if (bus.wbm_ack_o !== 3'b010 || bus.wbs_adr_o !== exp_adr ||
          bus.wbs_cti_o !== exp_cti) begin
        n_fail++;
        $display("FAIL burst_beat%0d: got ack %b adr %h cti %b want 010 %h %b",
                 b, bus.wbm_ack_o, bus.wbs_adr_o, bus.wbs_cti_o, exp_adr, exp_cti);
      end
      tick();
      n_cmp++;
      if (gnt_o !== 3'b010) begin
        n_fail++; $display("FAIL burst_hold%0d: got %b want 010", b, gnt_o);
      end
    end
    bus.wbs_ack_i        = 1'b0;
    bus.wbm_cyc_i[1]     = 1'b0;
    bus.wbm_stb_i[1]     = 1'b0;
    bus.wbm_cti_i[5:3]   = 3'b000;
    bus.wbm_adr_i[63:32] = 32'h2000_0000;
    tick();
    n_cmp++;
    if (gnt_o !== 3'b000) begin
      n_fail++; $display("FAIL burst_idle: got %b want 000", gnt_o);
    end
    tick();
    n_cmp++;
    if (gnt_o !== 3'b001) begin
      n_fail++; $display("FAIL burst_next: got %b want 001", gnt_o);
    end
    bus.wbm_cyc_i = '0;
    bus.wbm_stb_i = '0;
    tick();
  endtask

  task automatic test_err();
    bus.wbm_cyc_i[2] = 1'b1;
    bus.wbm_stb_i[2] = 1'b1;
    bus.wbm_we_i[2]  = 1'b1;
    tick();
    n_cmp++;
    if (gnt_o !== 3'b100 || bus.wbs_adr_o !== 32'hb300_0010 ||
        bus.wbs_we_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_req: got gnt %b adr %h we %b want 100 b3000010 1",
               gnt_o, bus.wbs_adr_o, bus.wbs_we_o);
    end
    bus.wbs_err_i = 1'b1;
    #1;
    n_cmp++;
    if (bus.wbm_err_o !== 3'b100 || bus.wbm_ack_o !== 3'b000 ||
        bus.wbm_rty_o !== 3'b000) begin
      n_fail++;
      $display("FAIL err_route: got err %b ack %b rty %b want 100 000 000",
               bus.wbm_err_o, bus.wbm_ack_o, bus.wbm_rty_o);
    end
    tick();
    bus.wbs_err_i = 1'b0;
    bus.wbs_rty_i = 1'b1;
    #1;
    n_cmp++;
    if (bus.wbm_rty_o !== 3'b100 || bus.wbm_err_o !== 3'b000) begin
      n_fail++;
      $display("FAIL rty_route: got rty %b err %b want 100 000",
               bus.wbm_rty_o, bus.wbm_err_o);
    end
    bus.wbs_rty_i = 1'b0;
    bus.wbm_cyc_i = '0;
    bus.wbm_stb_i = '0;
    bus.wbm_we_i  = '0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    bus.wbm_cyc_i[1]   = 1'b1;
    bus.wbm_stb_i[1]   = 1'b1;
    bus.wbm_cti_i[5:3] = 3'b010;
    tick();
    n_cmp++;
    if (gnt_o !== 3'b010) begin
      n_fail++; $display("FAIL rmid_gnt1: got %b want 010", gnt_o);
    end
    tick();
    rst = 1'b1;
    bus.wbm_cyc_i[0] = 1'b1;
    bus.wbm_stb_i[0] = 1'b1;
    tick();
    bus.wbs_ack_i = 1'b1;
    #1;
    n_cmp++;
    if (gnt_o !== 3'b000 || bus.wbs_cyc_o !== 1'b0 ||
        bus.wbs_stb_o !== 1'b0 || bus.wbm_ack_o !== 3'b000) begin
      n_fail++;
      $display("FAIL rmid_clear: got gnt %b cyc %b stb %b ack %b want 000 0 0 000",
               gnt_o, bus.wbs_cyc_o, bus.wbs_stb_o, bus.wbm_ack_o);
    end
    bus.wbs_ack_i = 1'b0;
    rst = 1'b0;
    tick();
    n_cmp++;
    if (gnt_o !== 3'b001) begin
      n_fail++; $display("FAIL rmid_regnt: got %b want 001", gnt_o);
    end
    bus.wbm_cyc_i = '0;
    bus.wbm_stb_i = '0;
    bus.wbm_cti_i = '0;
    tick();
  endtask

`ifdef WB_RR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bus.wbm_cyc_i[1] = 1'b1;
    bus.wbm_stb_i[1] = 1'b1;
    tick();
    for (int k = 1; k <= 15; k++) begin
      n_cmp++;
      if (bus.wbm_err_o !== 3'b000 || bus.wbs_stb_o !== 1'b1) begin
        n_fail++;
        $display("FAIL to_wait%0d: got err %b stb %b want 000 1",
                 k, bus.wbm_err_o, bus.wbs_stb_o);
      end
      tick();
    end
    n_cmp++;
    if (bus.wbm_err_o !== 3'b010 || bus.wbs_stb_o !== 1'b0 ||
        gnt_o !== 3'b010) begin
      n_fail++;
      $display("FAIL to_fire: got err %b stb %b gnt %b want 010 0 010",
               bus.wbm_err_o, bus.wbs_stb_o, gnt_o);
    end
    tick();
    n_cmp++;
    if (bus.wbm_err_o !== 3'b000 || bus.wbs_stb_o !== 1'b1 ||
        gnt_o !== 3'b010) begin
      n_fail++;
      $display("FAIL to_after: got err %b stb %b gnt %b want 000 1 010",
               bus.wbm_err_o, bus.wbs_stb_o, gnt_o);
    end
    bus.wbm_cyc_i = '0;
    bus.wbm_stb_i = '0;
    tick();
    n_cmp++;
    if (gnt_o !== 3'b000) begin
      n_fail++; $display("FAIL to_release: got %b want 000", gnt_o);
    end
  endtask
`endif

  initial begin
    init_bus();
    test_reset();
    test_simultaneous();
    test_round_robin();
    test_burst();
    test_err();
    test_reset_mid_burst();
`ifdef WB_RR_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
